// File: rtl/holy_axi_burst_master.sv
// Parametrised AXI4 INCR burst master: request/stream front end, beat counting, response checking.
// Optional watchdog enabled by defining HOLY_AXI_TIMEOUT_EN.
module holy_axi_burst_master #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int ID_WIDTH       = 4,
    parameter int AXI_ID         = 0,
    parameter int BURST_LEN      = 128,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,

    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [DATA_WIDTH-1:0] wr_data,

    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_last,

    output logic                  done,
    output logic                  err,
    output logic                  busy,
    output logic [7:0]            beat_ptr,

    output logic [ID_WIDTH-1:0]     m_axi_awid,
    output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [7:0]              m_axi_awlen,
    output logic [2:0]              m_axi_awsize,
    output logic [1:0]              m_axi_awburst,
    output logic                    m_axi_awvalid,
    input  logic                    m_axi_awready,

    output logic [DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                    m_axi_wlast,
    output logic                    m_axi_wvalid,
    input  logic                    m_axi_wready,

    input  logic [ID_WIDTH-1:0]     m_axi_bid,
    input  logic [1:0]              m_axi_bresp,
    input  logic                    m_axi_bvalid,
    output logic                    m_axi_bready,

    output logic [ID_WIDTH-1:0]     m_axi_arid,
    output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
    output logic [7:0]              m_axi_arlen,
    output logic [2:0]              m_axi_arsize,
    output logic [1:0]              m_axi_arburst,
    output logic                    m_axi_arvalid,
    input  logic                    m_axi_arready,

    input  logic [ID_WIDTH-1:0]     m_axi_rid,
    input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
    input  logic [1:0]              m_axi_rresp,
    input  logic                    m_axi_rlast,
    input  logic                    m_axi_rvalid,
    output logic                    m_axi_rready
);

    localparam int BYTES      = DATA_WIDTH / 8;
    localparam int SIZE       = $clog2(BYTES);
    localparam int ALIGN_BITS = $clog2(BURST_LEN * BYTES);
    localparam logic [7:0] LAST_BEAT = 8'(BURST_LEN - 1);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = {ADDR_WIDTH{1'b1}} << ALIGN_BITS;

    if (DATA_WIDTH != 32 && DATA_WIDTH != 64 && DATA_WIDTH != 128) begin : g_bad_data_width
        $error("holy_axi_burst_master: DATA_WIDTH must be 32, 64 or 128");
    end
    if (BURST_LEN < 1 || BURST_LEN > 256 || BURST_LEN * BYTES > 4096) begin : g_bad_burst_len
        $error("holy_axi_burst_master: BURST_LEN out of range or burst crosses 4 KiB");
    end

    typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_AW, S_W, S_B} state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  err_acc;

    logic ar_hs, aw_hs, r_hs, w_hs, b_hs;

    // Every AXI valid/ready is a decode of the state register, so nothing combinational
    // links req_valid to the bus; the R/W data paths are gated pass-throughs.
    assign ar_hs = m_axi_arvalid & m_axi_arready;
    assign aw_hs = m_axi_awvalid & m_axi_awready;
    assign r_hs  = m_axi_rvalid  & m_axi_rready;
    assign w_hs  = m_axi_wvalid  & m_axi_wready;
    assign b_hs  = m_axi_bvalid  & m_axi_bready;

    assign req_ready = (state == S_IDLE) & ~rst;
    assign busy      = (state != S_IDLE);

    assign m_axi_arvalid = (state == S_AR);
    assign m_axi_arid    = ID_WIDTH'(AXI_ID);
    assign m_axi_araddr  = addr_q;
    assign m_axi_arlen   = LAST_BEAT;
    assign m_axi_arsize  = 3'(SIZE);
    assign m_axi_arburst = 2'b01;

    assign m_axi_awvalid = (state == S_AW);
    assign m_axi_awid    = ID_WIDTH'(AXI_ID);
    assign m_axi_awaddr  = addr_q;
    assign m_axi_awlen   = LAST_BEAT;
    assign m_axi_awsize  = 3'(SIZE);
    assign m_axi_awburst = 2'b01;

    assign m_axi_rready = (state == S_R) & rd_ready;
    assign rd_valid     = (state == S_R) & m_axi_rvalid;
    assign rd_last      = (state == S_R) & m_axi_rlast;
    assign rd_data      = m_axi_rdata;

    assign m_axi_wvalid = (state == S_W) & wr_valid;
    assign wr_ready     = (state == S_W) & m_axi_wready;
    assign m_axi_wlast  = (state == S_W) & (beat_ptr == LAST_BEAT);
    assign m_axi_wdata  = wr_data;
    assign m_axi_wstrb  = '1;

    assign m_axi_bready = (state == S_B);

`ifdef HOLY_AXI_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd_cnt;
    logic            any_hs;
    assign any_hs = ar_hs | aw_hs | r_hs | w_hs | b_hs;
    logic unused_ok;
    assign unused_ok = ^{m_axi_bid, m_axi_rid};
`else
    logic unused_ok;
    assign unused_ok = ^{m_axi_bid, m_axi_rid, 32'(TIMEOUT_CYCLES)};
`endif

    // NOTE: all state updates use non-blocking assignments; later assignments in the
    // block deliberately override earlier ones (the watchdog abort wins over the case).
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            addr_q   <= '0;
            beat_ptr <= '0;
            err_acc  <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
`ifdef HOLY_AXI_TIMEOUT_EN
            wd_cnt   <= '0;
`endif
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        addr_q   <= req_addr & ALIGN_MASK;
                        beat_ptr <= '0;
                        err_acc  <= 1'b0;
                        state    <= req_write ? S_AW : S_AR;
                    end
                end
                S_AR: if (ar_hs) state <= S_R;
                S_AW: if (aw_hs) state <= S_W;
                S_R: begin
                    if (r_hs) begin
                        if (m_axi_rresp != 2'b00) err_acc <= 1'b1;
                        if (m_axi_rlast) begin
                            // Early rlast is flagged here; a late one already set err_acc.
                            done  <= 1'b1;
                            err   <= err_acc | (m_axi_rresp != 2'b00) | (beat_ptr != LAST_BEAT);
                            state <= S_IDLE;
                        end else if (beat_ptr == LAST_BEAT) begin
                            err_acc <= 1'b1;
                        end else begin
                            beat_ptr <= beat_ptr + 8'd1;
                        end
                    end
                end
                S_W: begin
                    if (w_hs) begin
                        if (beat_ptr == LAST_BEAT) state <= S_B;
                        else                       beat_ptr <= beat_ptr + 8'd1;
                    end
                end
                S_B: begin
                    if (b_hs) begin
                        done  <= 1'b1;
                        err   <= err_acc | (m_axi_bresp != 2'b00);
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
`ifdef HOLY_AXI_TIMEOUT_EN
            if (state == S_IDLE || any_hs) begin
                wd_cnt <= '0;
            end else if (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1)) begin
                wd_cnt <= '0;
                state  <= S_IDLE;
                done   <= 1'b1;
                err    <= 1'b1;
            end else begin
                wd_cnt <= wd_cnt + 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_holy_axi_burst_master.sv
// Directed bench for holy_axi_burst_master (BURST_LEN=4, DATA_WIDTH=32); slave behaviour is driven inline.
module tb_holy_axi_burst_master;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int IW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid, req_ready, req_write;
    logic [AW-1:0] req_addr;
    logic          wr_valid, wr_ready;
    logic [DW-1:0] wr_data;
    logic          rd_valid, rd_ready, rd_last;
    logic [DW-1:0] rd_data;
    logic          done, err, busy;
    logic [7:0]    beat_ptr;

    logic [IW-1:0] awid, bid, arid, rid;
    logic [AW-1:0] awaddr, araddr;
    logic [7:0]    awlen, arlen;
    logic [2:0]    awsize, arsize;
    logic [1:0]    awburst, arburst, bresp, rresp;
    logic          awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic          arvalid, arready, rlast, rvalid, rready;
    logic [DW-1:0] wdata, rdata;
    logic [DW/8-1:0] wstrb;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    holy_axi_burst_master #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .AXI_ID(5),
        .BURST_LEN(4), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write), .req_addr(req_addr),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
        .done(done), .err(err), .busy(busy), .beat_ptr(beat_ptr),
        .m_axi_awid(awid), .m_axi_awaddr(awaddr), .m_axi_awlen(awlen), .m_axi_awsize(awsize),
        .m_axi_awburst(awburst), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
        .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wlast(wlast), .m_axi_wvalid(wvalid),
        .m_axi_wready(wready),
        .m_axi_bid(bid), .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
        .m_axi_arid(arid), .m_axi_araddr(araddr), .m_axi_arlen(arlen), .m_axi_arsize(arsize),
        .m_axi_arburst(arburst), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
        .m_axi_rid(rid), .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rlast(rlast),
        .m_axi_rvalid(rvalid), .m_axi_rready(rready)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Caller sits at (or just after) a falling edge; returns 1ns after the falling edge where done shows.
    task automatic do_read(input logic [31:0] addr, input int n_beats, input int slverr_beat,
                           input int stall_beat, input logic exp_err, input string tag);
        req_valid = 1'b1; req_write = 1'b0; req_addr = addr;
        #1 check({tag, ".req_ready"}, req_ready, 1);
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        check({tag, ".arvalid"}, arvalid, 1);
        check({tag, ".araddr"}, araddr, addr & 32'hFFFF_FFF0);
        check({tag, ".arlen"}, arlen, 3);
        check({tag, ".arsize"}, arsize, 2);
        check({tag, ".arburst"}, arburst, 1);
        check({tag, ".arid"}, arid, 5);
        check({tag, ".busy"}, busy, 1);
        arready = 1'b1;
        @(negedge clk);
        arready = 1'b0;
        #1 check({tag, ".arvalid_drop"}, arvalid, 0);
        for (int i = 0; i < n_beats; i++) begin
            rvalid = 1'b1;
            rdata  = 32'hA0 + 32'(i);
            rresp  = (i == slverr_beat) ? 2'b10 : 2'b00;
            rlast  = (i == n_beats - 1);
            if (i == stall_beat) begin
                rd_ready = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    #1;
                    check({tag, ".stall_rready"}, rready, 0);
                    check({tag, ".stall_beat_ptr"}, beat_ptr, 8'(i));
                    @(negedge clk);
                end
            end
            rd_ready = 1'b1;
            #1;
            check({tag, ".rd_valid"}, rd_valid, 1);
            check({tag, ".rd_data"}, rd_data, 32'hA0 + 32'(i));
            check({tag, ".rd_last"}, rd_last, (i == n_beats - 1));
            check({tag, ".rready"}, rready, 1);
            check({tag, ".beat_ptr"}, beat_ptr, 8'(i));
            @(negedge clk);
        end
        rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00; rd_ready = 1'b0;
        #1;
        check({tag, ".done"}, done, 1);
        check({tag, ".err"}, err, exp_err);
        check({tag, ".busy_end"}, busy, 0);
        check({tag, ".req_ready_end"}, req_ready, 1);
    endtask

    // abort_beat >= 0 asserts rst for one cycle when that beat is being presented.
    task automatic do_write(input logic [31:0] addr, input logic [1:0] resp, input logic exp_err,
                            input int abort_beat, input string tag);
        int   k = 0;
        int   cyc = 0;
        logic wr_t = 1'b0;
        logic hs;
        logic aborted = 1'b0;
        req_valid = 1'b1; req_write = 1'b1; req_addr = addr;
        #1 check({tag, ".req_ready"}, req_ready, 1);
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        check({tag, ".awvalid"}, awvalid, 1);
        check({tag, ".awaddr"}, awaddr, addr & 32'hFFFF_FFF0);
        check({tag, ".awlen"}, awlen, 3);
        check({tag, ".awsize"}, awsize, 2);
        check({tag, ".awburst"}, awburst, 1);
        check({tag, ".awid"}, awid, 5);
        check({tag, ".arvalid"}, arvalid, 0);
        awready = 1'b1;
        @(negedge clk);
        awready = 1'b0;
        while (k < 4 && cyc < 20 && !aborted) begin
            wr_valid = 1'b1;
            wr_data  = 32'hB0 + 32'(k);
            wready   = wr_t;
            if (k == abort_beat) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                #1;
                check({tag, ".rst_wvalid"}, wvalid, 0);
                check({tag, ".rst_busy"}, busy, 0);
                check({tag, ".rst_req_ready"}, req_ready, 1);
                check({tag, ".rst_beat_ptr"}, beat_ptr, 0);
                check({tag, ".rst_done"}, done, 0);
                aborted = 1'b1;
            end else begin
                #1;
                check({tag, ".wvalid"}, wvalid, 1);
                check({tag, ".wdata"}, wdata, 32'hB0 + 32'(k));
                check({tag, ".wlast"}, wlast, (k == 3));
                check({tag, ".wr_ready"}, wr_ready, wr_t);
                check({tag, ".beat_ptr"}, beat_ptr, 8'(k));
                check({tag, ".wstrb"}, wstrb, 4'hF);
                hs = wr_t;
                @(negedge clk);
                if (hs) k++;
                wr_t = ~wr_t;
                cyc++;
            end
        end
        wr_valid = 1'b0; wready = 1'b0;
        if (!aborted) begin
            check({tag, ".beats"}, k, 4);
            #1;
            check({tag, ".bready"}, bready, 1);
            check({tag, ".wvalid_off"}, wvalid, 0);
            check({tag, ".wr_ready_off"}, wr_ready, 0);
            bvalid = 1'b1; bresp = resp;
            @(negedge clk);
            bvalid = 1'b0; bresp = 2'b00;
            #1;
            check({tag, ".done"}, done, 1);
            check({tag, ".err"}, err, exp_err);
            check({tag, ".busy_end"}, busy, 0);
        end
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
        wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
        awready = 1'b0; wready = 1'b0; bid = '0; bresp = '0; bvalid = 1'b0;
        arready = 1'b0; rid = '0; rdata = '0; rresp = '0; rlast = 1'b0; rvalid = 1'b0;
        repeat (3) @(negedge clk);
        check("rst.arvalid", arvalid, 0);
        check("rst.awvalid", awvalid, 0);
        check("rst.busy", busy, 0);
        check("rst.done", done, 0);
        check("rst.err", err, 0);
        check("rst.beat_ptr", beat_ptr, 0);
        check("rst.req_ready", req_ready, 0);
        check("rst.bready", bready, 0);
        check("rst.araddr", araddr, 0);
        rst = 1'b0;
        #1 check("rst.req_ready_after", req_ready, 1);
        @(negedge clk);

        do_read(32'h1000_0004, 4, -1, -1, 1'b0, "rd_basic");
        @(negedge clk);
        #1 check("rd_basic.done_pulse", done, 0);

        do_write(32'h2000_0000, 2'b00, 1'b0, -1, "wr_basic");
        @(negedge clk);
        #1 check("wr_basic.done_pulse", done, 0);

        do_read(32'h3000_0010, 4, 2, -1, 1'b1, "rd_slverr");
        // Issued while the previous done is still high.
        do_read(32'h3000_0020, 2, -1, -1, 1'b1, "rd_early_last");
        @(negedge clk);

        do_read(32'h4000_0000, 4, -1, 1, 1'b0, "rd_stall");
        @(negedge clk);

        do_write(32'h5000_0008, 2'b10, 1'b1, -1, "wr_bresp");
        @(negedge clk);

        do_write(32'h6000_0000, 2'b00, 1'b0, 2, "wr_reset");
        @(negedge clk);
        do_read(32'h7000_0000, 4, -1, -1, 1'b0, "rd_after_rst");
        @(negedge clk);

`ifdef HOLY_AXI_TIMEOUT_EN
        begin
            int n = 0;
            req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h8000_0000;
            @(negedge clk);
            req_valid = 1'b0;
            #1 check("to.arvalid", arvalid, 1);
            while (!done && n < 40) begin
                @(negedge clk);
                n++;
                #1;
            end
            check("to.cycles", n, 16);
            check("to.err", err, 1);
            check("to.arvalid_drop", arvalid, 0);
            check("to.busy", busy, 0);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
